// File: rtl/ysyx_220053_core_seq.sv
// ==========================================================================================
// ysyx_220053_core_seq: multi-cycle RV64 instruction sequencer (optional YSYX_SEQ_TIMEOUT_EN).
// Rev 1.0
// ==========================================================================================
`default_nettype none

module ysyx_220053_core_seq #(
    parameter logic [63:0] RESET_PC    = 64'h8000_0000,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [63:0] ifu_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_data,
    output logic [31:0] instr_o,
    input  logic        dec_wen,
    input  logic        dec_is_mem,
    input  logic        dec_is_trap,
    input  logic        dec_illegal,
    output logic        exu_start,
    input  logic        exu_done,
    input  logic        pc_redirect_i,
    input  logic [63:0] next_pc_i,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_wen,
    output logic [63:0] pc_o,
    output logic        halted,
    output logic [1:0]  trap_code,
    output logic [63:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_FETCH_W = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM_REQ = 3'd4,
        S_MEM_W   = 3'd5,
        S_WB      = 3'd6,
        S_TRAP    = 3'd7
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [1:0]  trap_n;
    logic        wen_q;
    logic        mem_q;
    logic        redirect_q;
    logic [63:0] npc_q;
    logic        first_exec;

`ifdef YSYX_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt;
    logic          waiting;
    logic          tmo_hit;

    assign waiting = (state == S_FETCH) || (state == S_FETCH_W) || (state == S_EXEC) ||
                     (state == S_MEM_REQ) || (state == S_MEM_W);
    // Fires in the TIMEOUT_CYC-th consecutive cycle spent waiting in one state.
    assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state_n != state) begin
            tmo_cnt <= '0;
        end else if (waiting) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        state_n = state;
        trap_n  = trap_code;
        case (state)
            S_FETCH:   if (ifu_req_ready) state_n = S_FETCH_W;
            S_FETCH_W: if (ifu_rsp_valid) state_n = S_DECODE;
            S_DECODE: begin
                if (dec_illegal) begin
                    state_n = S_TRAP;
                    trap_n  = 2'b10;
                end else if (dec_is_trap) begin
                    state_n = S_TRAP;
                    trap_n  = 2'b01;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC:    if (exu_done) state_n = mem_q ? S_MEM_REQ : S_WB;
            S_MEM_REQ: if (lsu_req_ready) state_n = S_MEM_W;
            S_MEM_W:   if (lsu_rsp_valid) state_n = S_WB;
            S_WB:      state_n = S_FETCH;
            S_TRAP:    state_n = S_TRAP;
            default:   state_n = S_FETCH;
        endcase
`ifdef YSYX_SEQ_TIMEOUT_EN
        // A legitimate transition in the same cycle wins over the watchdog.
        if (tmo_hit && (state_n == state)) begin
            state_n = S_TRAP;
            trap_n  = 2'b11;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc_o       <= RESET_PC;
            instr_o    <= '0;
            instr_cnt  <= '0;
            trap_code  <= '0;
            wen_q      <= 1'b0;
            mem_q      <= 1'b0;
            redirect_q <= 1'b0;
            npc_q      <= '0;
            first_exec <= 1'b0;
        end else begin
            state      <= state_n;
            trap_code  <= trap_n;
            // DECODE always lasts one cycle, so this marks the first EXEC cycle.
            first_exec <= (state == S_DECODE);
            case (state)
                S_FETCH_W: if (ifu_rsp_valid) instr_o <= ifu_rsp_data;
                S_DECODE: begin
                    wen_q <= dec_wen;
                    mem_q <= dec_is_mem;
                end
                S_EXEC: begin
                    if (exu_done) begin
                        redirect_q <= pc_redirect_i;
                        npc_q      <= next_pc_i;
                    end
                end
                S_WB: begin
                    pc_o      <= redirect_q ? npc_q : pc_o + 64'd4;
                    instr_cnt <= instr_cnt + 64'd1;
                end
                default: ;
            endcase
        end
    end

    assign ifu_req_valid = (state == S_FETCH);
    assign ifu_addr      = pc_o;
    assign exu_start     = (state == S_EXEC) && first_exec;
    assign lsu_req_valid = (state == S_MEM_REQ);
    assign rf_wen        = (state == S_WB) && wen_q;
    assign halted        = (state == S_TRAP);

endmodule

`default_nettype wire
